// File: rtl/scalar_pkg.sv
// Shared types and constants for the scalar issuer and its result FIFO.
package scalar_pkg;

  localparam int ELEM_IL = 4;
  localparam int ELEM_FL = 16;

  typedef logic signed [ELEM_IL+ELEM_FL-1:0] elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_FIRE,
    ST_WAIT,
    ST_DRAIN
  } issuer_state_t;

  localparam logic [1:0] UNIT_IDLE = 2'b00;
  localparam logic [1:0] UNIT_BUSY = 2'b01;
  localparam logic [1:0] UNIT_DONE = 2'b10;
  localparam logic [1:0] UNIT_ERR  = 2'b11;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;

endpackage

// File: rtl/result_fifo.sv
// Pointer-based result FIFO with registered count/full/empty flags.
// A push is accepted while full if a pop happens in the same cycle.
module result_fifo #(
  parameter int WIDTH = 321,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/scalar_issuer.sv
// Command-driven initiator: streams operand pairs into the scalar unit one at a
// time and queues each result, tagged with last-of-command, in a small FIFO.
module scalar_issuer
  import scalar_pkg::*;
#(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 16,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_mode,
  input  logic [7:0]           cmd_count,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic signed [IL+FL-1:0] src_a [size],
  input  logic signed [IL+FL-1:0] src_b [size],
  output logic [1:0]           unit_mode,
  output logic                 unit_input_ready,
  output logic signed [IL+FL-1:0] unit_in1 [size],
  output logic signed [IL+FL-1:0] unit_in2 [size],
  input  logic [1:0]           unit_state,
  input  logic signed [IL+FL-1:0] unit_out [size],
  output logic                 unit_output_taken,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [IL+FL-1:0] res_data [size],
  output logic                 res_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int EW = IL + FL;
  localparam int FW = size * EW + 1;

  issuer_state_t        state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           remaining_q, remaining_d;
  logic signed [EW-1:0] in1_q [size];
  logic signed [EW-1:0] in1_d [size];
  logic signed [EW-1:0] in2_q [size];
  logic signed [EW-1:0] in2_d [size];
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 fifo_push, fifo_full, fifo_empty;
  logic [FW-1:0]        fifo_push_data, fifo_pop_data;

  // The not-full gate here is what guarantees room for the one in-flight result.
  assign src_ready         = (state_q == ST_ISSUE) && (unit_state == UNIT_IDLE) && !fifo_full;
  assign cmd_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign unit_input_ready  = (state_q == ST_FIRE);
  assign unit_output_taken = (state_q == ST_WAIT) && (unit_state == UNIT_DONE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    done_d      = 1'b0;
    err_d       = err_q || (unit_state == UNIT_ERR);
    fifo_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          mode_d      = cmd_mode;
          remaining_d = cmd_count;
          if (cmd_count == 8'd0) done_d = 1'b1;
          else                   state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (src_valid && src_ready) begin
          in1_d   = src_a;
          in2_d   = src_b;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (unit_state == UNIT_DONE) begin
          fifo_push   = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q > 8'd1) ? ST_ISSUE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= 2'b00;
      remaining_q <= 8'd0;
      in1_q       <= '{default: '0};
      in2_q       <= '{default: '0};
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    fifo_push_data = '0;
    for (int i = 0; i < size; i++) begin
      fifo_push_data[i*EW +: EW] = unit_out[i];
    end
    fifo_push_data[FW-1] = (remaining_q == 8'd1);
  end

  result_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (res_ready),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    for (int i = 0; i < size; i++) begin
      res_data[i] = fifo_pop_data[i*EW +: EW];
    end
  end

  assign res_valid = !fifo_empty;
  assign res_last  = fifo_pop_data[FW-1];
  assign unit_mode = mode_q;
  assign unit_in1  = in1_q;
  assign unit_in2  = in2_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_scalar_issuer.sv
// Scoreboard bench for scalar_issuer with a behavioural model of the scalar unit.
module tb_scalar_issuer;
  import scalar_pkg::*;

  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int SIZE  = 16;
  localparam int DEPTH = 4;
  localparam int EW    = IL + FL;
  localparam int PW    = SIZE * EW;

  logic                 clk   = 1'b0;
  logic                 reset = 1'b1;
  logic                 cmd_valid, cmd_ready;
  logic [1:0]           cmd_mode;
  logic [7:0]           cmd_count;
  logic                 src_valid, src_ready;
  logic signed [EW-1:0] src_a [SIZE];
  logic signed [EW-1:0] src_b [SIZE];
  logic [1:0]           unit_mode;
  logic                 unit_input_ready;
  logic signed [EW-1:0] unit_in1 [SIZE];
  logic signed [EW-1:0] unit_in2 [SIZE];
  logic [1:0]           unit_state, model_state;
  logic                 inject_err;
  logic signed [EW-1:0] model_res [SIZE];
  logic                 unit_output_taken;
  logic                 res_valid, res_ready, res_last;
  logic signed [EW-1:0] res_data [SIZE];
  logic                 busy, done, err;

  int errors   = 0;
  int checks   = 0;
  int cycle    = 0;
  int fire_cnt = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  int last_hs  = -1;
  bit check_gap = 1'b0;
  logic [PW-1:0] exp_data_q [$];
  bit            exp_last_q [$];
  logic [PW-1:0] mon_act;

  scalar_issuer #(
    .IL (IL), .FL (FL), .size (SIZE), .DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_mode          (cmd_mode),
    .cmd_count         (cmd_count),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_a             (src_a),
    .src_b             (src_b),
    .unit_mode         (unit_mode),
    .unit_input_ready  (unit_input_ready),
    .unit_in1          (unit_in1),
    .unit_in2          (unit_in2),
    .unit_state        (unit_state),
    .unit_out          (model_res),
    .unit_output_taken (unit_output_taken),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .res_last          (res_last),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  assign unit_state = inject_err ? UNIT_ERR : model_state;

  task automatic checkOutput(input string name, input logic [PW:0] act, input logic [PW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic signed [EW-1:0] unit_op(input logic [1:0] m,
                                                   input logic signed [EW-1:0] a,
                                                   input logic signed [EW-1:0] b);
    logic signed [2*EW-1:0] wide;
    case (m)
      MODE_ADD: return a + b;
      MODE_SUB: return a - b;
      MODE_MUL: begin
        wide = (2*EW)'(a) * (2*EW)'(b);
        return EW'(wide >>> FL);
      end
      default: begin
        if (b == '0) return '0;
        wide = ((2*EW)'(a) <<< FL) / (2*EW)'(b);
        return EW'(wide);
      end
    endcase
  endfunction

  function automatic logic signed [EW-1:0] vec_a(input int pat, input int k, input int e);
    if (pat == 0) return 20'sh10000;
    return EW'(32'h10000 + k * 32'h1000 + e * 32'h10);
  endfunction

  function automatic logic signed [EW-1:0] vec_b(input int pat, input int k, input int e);
    if (pat == 0) return 20'sh08000;
    return EW'(32'h02000 + k * 32'h100 + e);
  endfunction

  // Unit model: idle -> busy on the operand pulse, result held until taken.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_state <= UNIT_IDLE;
      model_res   <= '{default: '0};
    end else begin
      case (model_state)
        UNIT_IDLE: if (unit_input_ready) begin
          model_state <= UNIT_BUSY;
          for (int e = 0; e < SIZE; e++) model_res[e] <= unit_op(unit_mode, unit_in1[e], unit_in2[e]);
        end
        UNIT_BUSY: model_state <= UNIT_DONE;
        UNIT_DONE: if (unit_output_taken) model_state <= UNIT_IDLE;
        default:   model_state <= UNIT_IDLE;
      endcase
    end
  end

  // Monitor: counts events and checks each popped result against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      exp_data_q.delete();
      exp_last_q.delete();
    end else begin
      if (!check_gap) last_hs = -1;
      if (unit_input_ready) fire_cnt++;
      if (done) done_cnt++;
      if (src_valid && src_ready) begin
        if (check_gap && last_hs >= 0) checkOutput("src_gap", cycle - last_hs, 4);
        last_hs = cycle;
        hs_cnt++;
      end
      if (res_valid && res_ready) begin
        for (int e = 0; e < SIZE; e++) mon_act[e*EW +: EW] = res_data[e];
        if (exp_data_q.size() == 0) checkOutput("unexpected_result", 1, 0);
        else begin
          checkOutput("res_data", mon_act, exp_data_q.pop_front());
          checkOutput("res_last", res_last, exp_last_q.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] mode, input int count, input int pat);
    logic [PW-1:0] exp;
    for (int k = 0; k < count; k++) begin
      for (int e = 0; e < SIZE; e++) begin
        if (pat == 0 && mode == MODE_ADD) exp[e*EW +: EW] = 20'h18000;
        else exp[e*EW +: EW] = unit_op(mode, vec_a(pat, k, e), vec_b(pat, k, e));
      end
      exp_data_q.push_back(exp);
      exp_last_q.push_back(k == count - 1);
    end
    checkOutput("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = 8'(count);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_one(input int pat, input int k);
    bit got = 1'b0;
    for (int e = 0; e < SIZE; e++) begin
      src_a[e] = vec_a(pat, k, e);
      src_b[e] = vec_b(pat, k, e);
    end
    src_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = src_ready;
      @(posedge clk); #1;
    end
    if (!got) checkOutput("src_timeout", 0, 1);
  endtask

  task automatic run_vectors(input int count, input int pat);
    for (int k = 0; k < count; k++) drive_one(pat, k);
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(posedge clk); #1;
      seen = done;
    end
    checkOutput(name, seen, 1);
    checkOutput("busy_after_done", busy, 0);
    @(posedge clk); #1;
    checkOutput("done_single_pulse", done, 0);
  endtask

  initial begin
    int f0, h0, d0;
    cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_count = 8'd0;
    src_valid = 1'b0; res_ready = 1'b0; inject_err = 1'b0;
    src_a = '{default: '0};
    src_b = '{default: '0};
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_unit_mode", unit_mode, 0);
    checkOutput("rst_unit_in1", unit_in1[0], 0);
    checkOutput("rst_res_data", res_data[0], 0);
    checkOutput("rst_input_ready", unit_input_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single add");
    res_ready = 1'b1;
    f0 = fire_cnt;
    applyStimulus(MODE_ADD, 1, 0);
    checkOutput("add_unit_mode", unit_mode, MODE_ADD);
    run_vectors(1, 0);
    wait_done("add_done");
    checkOutput("add_fire_pulses", fire_cnt - f0, 1);
    checkOutput("add_sb_empty", exp_data_q.size(), 0);

    $display("[TB] zero-count command");
    f0 = fire_cnt;
    applyStimulus(MODE_SUB, 0, 1);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    @(posedge clk); #1;
    checkOutput("zero_done_cleared", done, 0);
    checkOutput("zero_no_fire", fire_cnt - f0, 0);

    $display("[TB] throughput");
    f0 = fire_cnt;
    check_gap = 1'b1;
    applyStimulus(MODE_ADD, 8, 1);
    run_vectors(8, 1);
    wait_done("tput_done");
    check_gap = 1'b0;
    checkOutput("tput_fire_pulses", fire_cnt - f0, 8);
    checkOutput("tput_sb_empty", exp_data_q.size(), 0);

    $display("[TB] backpressure");
    res_ready = 1'b0;
    h0 = hs_cnt;
    applyStimulus(MODE_SUB, 6, 1);
    checkOutput("bp_unit_mode", unit_mode, MODE_SUB);
    fork
      run_vectors(6, 1);
      begin
        repeat (40) @(posedge clk);
        #1;
        checkOutput("bp_pushes", hs_cnt - h0, DEPTH);
        checkOutput("bp_src_ready", src_ready, 0);
        checkOutput("bp_res_valid", res_valid, 1);
        checkOutput("bp_queued", exp_data_q.size(), 6);
        res_ready = 1'b1;
      end
    join
    wait_done("bp_done");
    checkOutput("bp_sb_empty", exp_data_q.size(), 0);

    $display("[TB] reset mid-command");
    d0 = done_cnt;
    applyStimulus(MODE_MUL, 3, 1);
    drive_one(1, 0);
    src_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_busy", busy, 1);
    checkOutput("mid_unit_mode", unit_mode, MODE_MUL);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_cmd_ready", cmd_ready, 1);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_unit_mode", unit_mode, 0);
    checkOutput("mid_rst_unit_in1", unit_in1[3], 0);
    checkOutput("mid_rst_taken", unit_output_taken, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_no_done", done_cnt - d0, 0);
    f0 = fire_cnt;
    applyStimulus(MODE_ADD, 2, 1);
    run_vectors(2, 1);
    wait_done("post_rst_done");
    checkOutput("post_rst_fire", fire_cnt - f0, 2);
    checkOutput("post_rst_sb_empty", exp_data_q.size(), 0);

    $display("[TB] illegal unit state");
    checkOutput("err_before", err, 0);
    inject_err = 1'b1;
    @(posedge clk); #1;
    inject_err = 1'b0;
    checkOutput("err_set", err, 1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("err_sticky", err, 1);
    reset = 1'b0;
    #1;
    checkOutput("err_reset", err, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/scalar_issuer.md
# scalar_issuer

Command-driven initiator for the scalar elementwise unit. Accepts a command (mode, vector count), streams operand vector pairs into the unit over its `input_ready` / `state` / `output_taken` handshake, and collects each result vector into a small result FIFO. Results leave on a valid/ready port with a last-of-command marker. The block sits between the operand buffers and the scalar unit in the compute datapath.

## Interface

Parameters:
- `IL`, 4, integer bits of a fixed-point element.
- `FL`, 16, fraction bits of a fixed-point element.
- `size`, 16, elements per vector.
- `DEPTH`, 4, result FIFO entries (power of 2, ≥2).

Ports (one clock; `reset` is asynchronous and active-low):
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_mode` in 2: operation (00 add, 01 sub, 10 mul, 11 div).
- `cmd_count` in 8: number of vector pairs in the command.
- `src_valid` in 1; `src_ready` out 1: operand handshake.
- `src_a`, `src_b` in signed [IL+FL-1:0] × size: operand vectors.
- `unit_mode` out 2: mode to the unit.
- `unit_input_ready` out 1: operand-valid pulse to the unit.
- `unit_in1`, `unit_in2` out signed [IL+FL-1:0] × size: operands to the unit.
- `unit_state` in 2: unit state (00 idle, 01 busy, 10 result held).
- `unit_out` in signed [IL+FL-1:0] × size: unit result.
- `unit_output_taken` out 1: result-consumed pulse to the unit.
- `res_valid` out 1; `res_ready` in 1: result handshake.
- `res_data` out signed [IL+FL-1:0] × size: result vector.
- `res_last` out 1: result is the final one of its command.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse at command completion.
- `err` out 1: sticky; set when `unit_state`==11 is seen.

## Operation

- FSM states: IDLE, ISSUE, FIRE, WAIT, DRAIN.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`, latch `cmd_mode` into `unit_mode` and set `remaining`=`cmd_count`.
  - If `cmd_count`==0: pulse `done` next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- **ISSUE:** `src_ready` = (`unit_state`==00) && FIFO not full. On a `src` handshake, register `src_a`/`src_b` into `unit_in1`/`unit_in2` and go to FIRE.
- **FIRE:** `unit_input_ready`=1 for exactly this cycle; go to WAIT.
- **WAIT:** when `unit_state`==10:
  - Assert `unit_output_taken` combinationally in the same cycle.
  - Push `{last, unit_out}` into the FIFO, with last = (`remaining`==1).
  - Decrement `remaining`. Go to ISSUE if it was >1, else DRAIN.
- **DRAIN:** once the FIFO is empty, pulse `done` and go to IDLE.
- `unit_mode` is held constant from command accept until the next command is accepted.
- Operand registers hold their value after FIRE; they are not cleared.
- The FIFO accepts a push and a pop in the same cycle when full: count unchanged, no overflow.
- Only one vector is ever in flight. The not-full check at ISSUE guarantees space at push time.
- `err` is set by `unit_state`==11 in any state and cleared only by reset. The FSM keeps waiting (no recovery).
- Reset mid-command aborts it. All state clears and no `done` is issued. The unit is reset by its own reset.

## Timing

- Reset values: all outputs 0, except `cmd_ready`=1 because the FSM is in IDLE. `unit_mode`, `unit_in*` and `res_data` reset to 0. FIFO empty.
- Command accept edge → ISSUE on the next cycle.
- Per vector: src handshake at cycle t, FIRE at t+1, unit reaches 01 at t+2 and 10 at t+3. `unit_output_taken` and the FIFO push occur at t+3. The unit is back at 00 at t+4, so the next src handshake is possible at t+4.
- Throughput: 1 vector per 4 cycles.
- `res_valid` rises the cycle after the push (registered FIFO output).
- `done` pulses the cycle after the last FIFO pop, i.e. the cycle DRAIN sees the FIFO empty.
- `res_ready` held low stalls ISSUE once DEPTH results are queued. No result is dropped.

## Structure

- Package `scalar_pkg`:
  - `issuer_state_t` enum.
  - Unit state constants `UNIT_IDLE`/`UNIT_BUSY`/`UNIT_DONE` (00/01/10).
  - Mode constants `MODE_ADD`/`MODE_SUB`/`MODE_MUL`/`MODE_DIV`.
  - `elem_t` = signed [IL+FL-1:0].
- Sub-module `result_fifo`:
  - Parameterised width (size·(IL+FL)+1) and DEPTH.
  - Pointer-based, with registered `count`, `full` and `empty`.
  - Same clock and asynchronous active-low reset.

## Test plan

- **Single add:** cmd mode=00, count=1; src_a all 0x10000 (1.0), src_b all 0x08000 (0.5) → `unit_input_ready` one pulse; `res_data` all 0x18000 with `res_last`=1; `done` one pulse; `busy` back to 0.
- **Zero-count command:** `cmd_count`=0 → `done` pulses one cycle after accept; no `unit_input_ready`; `busy` stays 0.
- **Throughput:** count=8 with `res_ready`=1 and `src_valid`=1 → src handshakes exactly 4 cycles apart; 8 results in order; `res_last` only on the 8th.
- **Backpressure:** count=6 with `res_ready`=0 → exactly 4 (DEPTH) pushes, then `src_ready` stays 0. Raising `res_ready` drains all 6 results in order with none lost.
- **Reset mid-command:** assert `reset` low during WAIT → all outputs at reset values immediately; FIFO empty; no `done`. A new command afterwards completes normally.
- **Illegal unit state:** drive `unit_state`=11 for one cycle → `err`=1 and it stays 1 until reset.
